// File: rtl/turbo_qpp_addr_gen_if.sv
// Bus bundle for the turbo QPP address generator: sweep control and
// configuration flowing in, per-lane natural/interleaved addresses out.
interface turbo_qpp_addr_gen_if #(
  parameter int P  = 8,
  parameter int AW = 13
);
  // Sweep control
  logic            start;
  logic            en;
  logic            decMode;

  // Block configuration, captured on start
  logic [AW-1:0]   blockSize;
  logic [AW-1:0]   winLen;
  logic [P*AW-1:0] pi_init;
  logic [P*AW-1:0] g_init;
  logic [AW-1:0]   d_step;

  // Per-lane address outputs and status
  logic [P*AW-1:0] addr_nat;
  logic [P*AW-1:0] addr_int;
  logic [P*AW-1:0] addr_sel;
  logic            valid;
  logic            last;
  logic            busy;
  logic            done;

  // Side that drives the sweep (decoder controller, testbench)
  modport master (
    output start, en, decMode, blockSize, winLen, pi_init, g_init, d_step,
    input  addr_nat, addr_int, addr_sel, valid, last, busy, done
  );

  // Side that generates addresses (this block)
  modport slave (
    input  start, en, decMode, blockSize, winLen, pi_init, g_init, d_step,
    output addr_nat, addr_int, addr_sel, valid, last, busy, done
  );
endinterface

// File: rtl/turbo_qpp_addr_gen.sv
// Parallel QPP interleaver address generator for a windowed turbo decoder.
// P lanes each sweep one window of length M. Lane w walks natural addresses
// w*M + i and interleaved addresses pi(w*M + i). The interleaved sequence
// uses the QPP second-difference recurrence, so the datapath only needs
// modular adders:
//   pi(x+1) = pi(x) + g(x)   mod K
//   g(x+1)  = g(x) + 2*f2    mod K
module turbo_qpp_addr_gen #(
  parameter int P  = 8,
  parameter int AW = 13
) (
  input logic                 clk,
  input logic                 reset,
  turbo_qpp_addr_gen_if.slave bus
);

  // Sweep control states; reset lands in IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;

  // Latched configuration: block length K, window length M, 2*f2 mod K
  logic [AW-1:0] k_q;
  logic [AW-1:0] m_q;
  logic [AW-1:0] d_q;

  // Position within the window, shared by all lanes
  logic [AW-1:0] i_q;

  // Per-lane recurrence state. nat_q starts at the lane base w*M and
  // steps alongside i, so it always equals w*M + i.
  logic [AW-1:0] nat_q [P];
  logic [AW-1:0] pi_q  [P];
  logic [AW-1:0] g_q   [P];

  // Lane bases w*M for the load, built from winLen by chained addition
  logic [AW-1:0] base_load [P];

  logic          at_end;
  logic          valid;
  logic          last;
  logic          advance;

  logic [P*AW-1:0] nat_pk;
  logic [P*AW-1:0] int_pk;

  // Modular add of two residues already below k: one conditional subtract.
  // The sum is kept one bit wider so a carry out of AW bits is not lost.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] k);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) begin
      sum = sum - {1'b0, k};
    end
    return sum[AW-1:0];
  endfunction

  // Handshake: addresses are consumed whenever we are running and enabled
  assign at_end  = (i_q == (m_q - AW'(1)));
  assign valid   = (state_q == ST_RUN) && bus.en;
  assign last    = valid && at_end;
  assign advance = valid && !at_end;

  // Lane bases 0, M, 2M, ... as a running sum, avoiding a multiplier
  always_comb begin
    logic [AW-1:0] acc;
    acc = '0;
    for (int w = 0; w < P; w++) begin
      base_load[w] = acc;
      acc          = acc + bus.winLen;
    end
  end

  // Next-state logic; start wins from every state, including a last cycle
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (last) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture K, M and the second difference at the start of each sweep
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
      m_q <= '0;
      d_q <= '0;
    end else if (bus.start) begin
      k_q <= bus.blockSize;
      m_q <= bus.winLen;
      d_q <= bus.d_step;
    end
  end

  // Window position: cleared on start, steps on every non-final valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q <= '0;
    end else if (bus.start) begin
      i_q <= '0;
    end else if (advance) begin
      i_q <= i_q + AW'(1);
    end
  end

  // Lane recurrences: load initial values on start, step together on advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these arrays are a handful of flops per lane, not a RAM, so they
      // take the async reset like any other register.
      for (int w = 0; w < P; w++) begin
        nat_q[w] <= '0;
        pi_q[w]  <= '0;
        g_q[w]   <= '0;
      end
    end else if (bus.start) begin
      for (int w = 0; w < P; w++) begin
        nat_q[w] <= base_load[w];
        pi_q[w]  <= bus.pi_init[w*AW +: AW];
        g_q[w]   <= bus.g_init[w*AW +: AW];
      end
    end else if (advance) begin
      for (int w = 0; w < P; w++) begin
        nat_q[w] <= nat_q[w] + AW'(1);
        pi_q[w]  <= mod_add(pi_q[w], g_q[w], k_q);
        g_q[w]   <= mod_add(g_q[w], d_q, k_q);
      end
    end
  end

  // Pack lane registers onto the flat output buses
  always_comb begin
    nat_pk = '0;
    int_pk = '0;
    for (int w = 0; w < P; w++) begin
      nat_pk[w*AW +: AW] = nat_q[w];
      int_pk[w*AW +: AW] = pi_q[w];
    end
  end

  assign bus.addr_nat = nat_pk;
  assign bus.addr_int = int_pk;
  // Order selection is a pure mux so a mode flip shows up in the same cycle
  assign bus.addr_sel = bus.decMode ? int_pk : nat_pk;
  assign bus.valid    = valid;
  assign bus.last     = last;
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.done     = (state_q == ST_DONE);

endmodule
